// File: rtl/wb_copy_master.sv
// Wishbone classic initiator that copies a block of words from src to dst.
// It reads one word, writes it back, and separates every strobe with a mandatory idle gap cycle.
module wb_copy_master #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   src_adr_i,
  input  logic [ADDR_WIDTH-1:0]   dst_adr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    err_timeout_o,
  output logic [ADDR_WIDTH-1:0]   err_adr_o,
  output logic [LEN_WIDTH-1:0]    remain_o,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic                    we_o,
  output logic [SELECT_WIDTH-1:0] sel_o,
  output logic                    stb_o,
  output logic                    cyc_o,
  input  logic                    ack_i,
  input  logic                    stall_i
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(SELECT_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(SELECT_WIDTH - 1));

  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP} state_t;

  state_t                  state_q, state_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [LEN_WIDTH-1:0]    remain_q, remain_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    err_to_q, err_to_d;
  logic [ADDR_WIDTH-1:0]   err_adr_q, err_adr_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;

  logic in_strobe;
  logic stall_hit;
  logic tmo_hit;

  // tmo_q is zero only in the first cycle of a strobe, which is when stall_i is stale.
  assign in_strobe = (state_q == RD) || (state_q == WR);
  assign stall_hit = in_strobe && !ack_i && stall_i && (tmo_q != '0);
  assign tmo_hit   = in_strobe && !ack_i && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    src_d     = src_q;
    dst_d     = dst_q;
    remain_d  = remain_q;
    done_d    = 1'b0;
    err_d     = err_q;
    err_to_d  = err_to_q;
    err_adr_d = err_adr_q;
    tmo_d     = tmo_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d     = 1'b0;
          err_to_d  = 1'b0;
          err_adr_d = '0;
          if (len_i == '0) begin
            done_d   = 1'b1;
            remain_d = '0;
          end else begin
            src_d    = src_adr_i & ALIGN_MASK;
            dst_d    = dst_adr_i & ALIGN_MASK;
            remain_d = len_i;
            cyc_d    = 1'b1;
            stb_d    = 1'b1;
            we_d     = 1'b0;
            adr_d    = src_adr_i & ALIGN_MASK;
            tmo_d    = '0;
            state_d  = RD;
          end
        end
      end

      RD: begin
        if (ack_i) begin
          dat_d   = dat_i;
          stb_d   = 1'b0;
          state_d = RD_GAP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      RD_GAP: begin
        stb_d   = 1'b1;
        we_d    = 1'b1;
        adr_d   = dst_q;
        tmo_d   = '0;
        state_d = WR;
      end

      WR: begin
        if (ack_i) begin
          remain_d = remain_q - LEN_WIDTH'(1);
          src_d    = src_q + STEP;
          dst_d    = dst_q + STEP;
          if (remain_q == LEN_WIDTH'(1)) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stb_d   = 1'b0;
            state_d = WR_GAP;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      WR_GAP: begin
        stb_d   = 1'b1;
        we_d    = 1'b0;
        adr_d   = src_q;
        tmo_d   = '0;
        state_d = RD;
      end

      default: state_d = IDLE;
    endcase

    // An address error takes precedence over a simultaneous timeout; ack already excluded both.
    if (stall_hit || tmo_hit) begin
      err_d     = 1'b1;
      err_to_d  = !stall_hit;
      err_adr_d = adr_q;
      cyc_d     = 1'b0;
      stb_d     = 1'b0;
      we_d      = 1'b0;
      done_d    = 1'b1;
      tmo_d     = '0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      remain_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_to_q  <= 1'b0;
      err_adr_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      remain_q  <= remain_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_to_q  <= err_to_d;
      err_adr_q <= err_adr_d;
      tmo_q     <= tmo_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign err_timeout_o = err_to_q;
  assign err_adr_o     = err_adr_q;
  assign remain_o      = remain_q;
  assign adr_o         = adr_q;
  assign dat_o         = dat_q;
  assign we_o          = we_q;
  assign sel_o         = '1;
  assign stb_o         = stb_q;
  assign cyc_o         = cyc_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: a RAM slave model with wait states, an address-error region and
// a no-ack mode, plus a reference copy model feeding a scoreboard checked by a monitor.
module tb_wb_copy_master;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_i = 1'b0;
  logic [31:0] src_adr_i = '0, dst_adr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o, err_timeout_o;
  logic [31:0] err_adr_o, adr_o, dat_o;
  logic [15:0] remain_o;
  logic [31:0] dat_i;
  logic        we_o, stb_o, cyc_o, ack_i, stall_i;
  logic [3:0]  sel_o;

  wb_copy_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SELECT_WIDTH(4), .LEN_WIDTH(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_timeout_o(err_timeout_o),
    .err_adr_o(err_adr_o), .remain_o(remain_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
    .we_o(we_o), .sel_o(sel_o), .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .stall_i(stall_i)
  );

  // Slave configuration, set only while the master is idle.
  int          ws = 0;
  bit          no_ack = 1'b0;
  bit          bad_en = 1'b0;
  logic [31:0] bad_lo = '0;
  bit          reinit_req = 1'b0;
  logic [31:0] reinit_seed = '0;
  bit          poke_en = 1'b0;
  logic [9:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int          wcnt;
  int          cyc_cnt = 0;
  int          start_cyc = 0;

  function automatic logic [31:0] pat(logic [31:0] seed, int i);
    return seed ^ (32'(i) * 32'h9E37_79B1) ^ 32'(i);
  endfunction

  function automatic bit is_bad(logic [31:0] a);
    return bad_en && (a >= bad_lo);
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Registered-ack slave: ack after ws extra strobe cycles; stall reflects last cycle's address.
  always @(posedge clk) begin
    if (reinit_req)
      for (int i = 0; i < 1024; i++) mem[i] <= pat(reinit_seed, i);
    if (poke_en) mem[poke_idx] <= poke_val;
    if (rst) begin
      ack_i   <= 1'b0;
      stall_i <= 1'b0;
      dat_i   <= '0;
      wcnt    <= 0;
    end else begin
      stall_i <= cyc_o && stb_o && is_bad(adr_o);
      if (cyc_o && stb_o && !ack_i && !no_ack && !is_bad(adr_o)) begin
        if (wcnt == ws) begin
          ack_i <= 1'b1;
          wcnt  <= 0;
          if (we_o) mem[adr_o[11:2]] <= dat_o;
          else      dat_i <= mem[adr_o[11:2]];
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        ack_i <= 1'b0;
        if (!stb_o) wcnt <= 0;
      end
    end
  end

  typedef struct { bit we; logic [31:0] adr; logic [31:0] dat; } acc_t;
  typedef struct { int lat; bit err; bit to; logic [31:0] eadr; logic [15:0] rem; } done_t;
  acc_t  exp_acc[$];
  done_t exp_done[$];

  int total = 0;
  int bad = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_acc(bit we, logic [31:0] adr, logic [31:0] dat);
    acc_t a;
    a.we = we; a.adr = adr; a.dat = dat;
    exp_acc.push_back(a);
  endtask

  // Reference: sequential word copy; every access costs 3+ws cycles, the first strobe rises in cycle 1.
  task automatic model(logic [31:0] s, logic [31:0] d, logic [15:0] n);
    logic [31:0] sa, da, ra, wa, v;
    int t;
    done_t e;
    sa = s & ~32'h3; da = d & ~32'h3; t = 1;
    e.lat = 0; e.err = 0; e.to = 0; e.eadr = '0; e.rem = '0;
    if (n == 0) begin
      e.lat = 1; exp_done.push_back(e); return;
    end
    if (no_ack) begin
      e.lat = 1 + TMO; e.err = 1; e.to = 1; e.eadr = sa; e.rem = n;
      exp_done.push_back(e); return;
    end
    for (int i = 0; i < int'(n); i++) begin
      ra = sa + 32'(4 * i);
      if (is_bad(ra)) begin
        e.lat = t + 2; e.err = 1; e.eadr = ra; e.rem = 16'(int'(n) - i);
        exp_done.push_back(e); return;
      end
      v = ref_mem[ra[11:2]];
      push_acc(1'b0, ra, v);
      t += 3 + ws;
      wa = da + 32'(4 * i);
      if (is_bad(wa)) begin
        e.lat = t + 2; e.err = 1; e.eadr = wa; e.rem = 16'(int'(n) - i);
        exp_done.push_back(e); return;
      end
      push_acc(1'b1, wa, v);
      ref_mem[wa[11:2]] = v;
      t += 3 + ws;
    end
    e.lat = t - 1;
    exp_done.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every acknowledged access and on every done pulse.
  initial begin
    acc_t  a;
    done_t d;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_acc.delete();
        exp_done.delete();
      end else begin
        check("busy_vs_cyc", busy_o, cyc_o);
        if (cyc_o && stb_o && ack_i) begin
          if (exp_acc.size() == 0) check("acc_unexpected", 1, 0);
          else begin
            a = exp_acc.pop_front();
            check("acc_we", we_o, a.we);
            check("acc_adr", adr_o, a.adr);
            if (a.we) check("acc_wdat", dat_o, a.dat);
            check("acc_sel", sel_o, 4'hF);
          end
        end
        if (done_o) begin
          if (exp_done.size() == 0) check("done_unexpected", 1, 0);
          else begin
            d = exp_done.pop_front();
            check("done_latency", cyc_cnt - start_cyc, d.lat);
            check("done_err", err_o, d.err);
            check("done_err_timeout", err_timeout_o, d.to);
            check("done_remain", remain_o, d.rem);
            if (d.err) check("done_err_adr", err_adr_o, d.eadr);
            check("done_busy", busy_o, 0);
            check("done_pending_acc", exp_acc.size(), 0);
            $display("copy done lat=%0d err=%0d to=%0d rem=%0d eadr=%08h",
                     cyc_cnt - start_cyc, err_o, err_timeout_o, remain_o, err_adr_o);
          end
        end
      end
    end
  end

  task automatic reinit(logic [31:0] seed);
    @(negedge clk);
    reinit_seed = seed; reinit_req = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(seed, i);
    @(negedge clk);
    reinit_req = 1'b0;
  endtask

  task automatic poke(logic [31:0] adr, logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = adr[11:2]; poke_val = val;
    ref_mem[adr[11:2]] = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic issue(logic [31:0] s, logic [31:0] d, logic [15:0] n);
    @(negedge clk);
    src_adr_i = s; dst_adr_i = d; len_i = n; start_i = 1'b1;
    start_cyc = cyc_cnt;
    model(s, d, n);
    @(negedge clk);
    start_i = 1'b0; src_adr_i = $urandom; dst_adr_i = $urandom; len_i = 16'($urandom);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 2000 && exp_done.size() != 0; c++) @(negedge clk);
    if (exp_done.size() != 0) begin
      check("done_timeout", 0, 1);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk); rst = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_copy(logic [31:0] s, logic [31:0] d, logic [15:0] n, bit busy_pulse);
    issue(s, d, n);
    if (busy_pulse) begin
      repeat (2) @(negedge clk);
      start_i = 1'b1; len_i = 16'd1; src_adr_i = 32'h0; dst_adr_i = 32'h0;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", {err_o, err_timeout_o}, 0);
    check("rst_err_adr", err_adr_o, 0);
    check("rst_remain", remain_o, 0);

    reinit(32'h1234_5678);
    poke(32'h100, 32'hA5A5_0001);
    poke(32'h104, 32'hA5A5_0002);
    do_copy(32'h100, 32'h200, 16'd2, 1'b0);

    // Zero length: done next cycle, no bus activity at all.
    issue(32'h40, 32'h80, 16'd0);
    for (int i = 0; i < 3; i++) begin
      check("len0_cyc", cyc_o, 0);
      check("len0_busy", busy_o, 0);
      @(negedge clk);
    end
    wait_done();

    ws = 3;
    do_copy(32'h300, 32'h500, 16'd1, 1'b0);
    ws = 0;

    bad_en = 1'b1; bad_lo = 32'h400;
    do_copy(32'h3FC, 32'h200, 16'd2, 1'b0);
    bad_en = 1'b0;

    no_ack = 1'b1;
    do_copy(32'h80, 32'h600, 16'd3, 1'b0);
    no_ack = 1'b0;
    check("err_sticky", err_o, 1);
    check("err_timeout_sticky", err_timeout_o, 1);
    do_copy(32'h10, 32'h20, 16'd1, 1'b0);
    check("err_cleared", err_o, 0);

    do_copy(32'hFFFF_FFFB, 32'h0000_0707, 16'd4, 1'b0);
    do_copy(32'h100, 32'h104, 16'd4, 1'b1);

    // Reset during the write of word 3 of a 10-word copy.
    reinit(32'hCAFE_0001);
    issue(32'h800, 32'hA00, 16'd10);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (stb_o && we_o && remain_o == 16'd8) found = 1'b1;
    end
    check("rst_point_found", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cyc", cyc_o, 0);
    check("midrst_stb", stb_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_busy", busy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    reinit(32'h0BAD_F00D);
    do_copy(32'h800, 32'hA00, 16'd4, 1'b0);

    for (int it = 0; it < 40; it++) begin
      logic [31:0] s, d;
      logic [15:0] n;
      bit pulse;
      ws = $urandom_range(0, 3);
      bad_en = ($urandom_range(0, 4) == 0);
      bad_lo = $urandom;
      no_ack = !bad_en && ($urandom_range(0, 9) == 0);
      s = $urandom; d = $urandom;
      n = 16'($urandom_range(0, 6));
      pulse = !bad_en && !no_ack && (n != 0) && $urandom_range(0, 1) == 1;
      do_copy(s, d, n, pulse);
    end
    bad_en = 1'b0; no_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end
endmodule
